mod_arith_seq: RTL

// - Parametrised sequential modular ALU; successor to the fixed 256-bit mod_arith datapath.
// - Takes signed-digit operands (value = p - n) and a run-time modulus M.
// - Computes ADD/SUB/MUL/NEG/DBL/SQR mod M with an en/ready/done handshake.
// - Returns a canonical result (zn = 0) and keeps the previous result for chained ops.

---
 rtl/mod_arith_pkg.sv | 25 ++
 rtl/mod_arith_step.sv | 24 ++
 rtl/mod_arith_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mod_arith_pkg.sv
// Shared encodings for the sequential modular ALU: opcodes, FSM states and
// the parameter legality check used at elaboration.
package mod_arith_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_NEG = 3'd3,
        OP_DBL = 3'd4,
        OP_SQR = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_EXEC,
        S_FIN
    } state_e;

    function automatic bit digits_ok(input int width, input int digits);
        return (digits == 1 || digits == 2 || digits == 4) && (width >= 4) && (width % digits == 0);
    endfunction

endpackage

// File: rtl/mod_arith_step.sv
// One Blakley step: acc' = 2*acc + bit*Y, reduced into [0,M) with at most
// two conditional subtractions (2*acc + Y < 3M when acc, Y < M).
module mod_arith_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH+1:0] acc_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH+1:0] acc_o
);

    logic [WIDTH+1:0] m_w, t, u;
    logic             unused_msb;

    // acc is always below M, so its top bit never carries information
    assign unused_msb = acc_i[WIDTH+1];

    assign m_w   = {2'b00, m_i};
    assign t     = {acc_i[WIDTH:0], 1'b0} + (bit_i ? {2'b00, y_i} : '0);
    assign u     = (t >= m_w) ? t - m_w : t;
    assign acc_o = (u >= m_w) ? u - m_w : u;

endmodule

// File: rtl/mod_arith_seq.sv
// Sequential modular ALU over signed-digit operands with a run-time modulus;
// result is canonical in [0,M) and the previous result is kept for chaining.
module mod_arith_seq
    import mod_arith_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int DIGITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic [2:0]       op_i,
    input  logic             opt_accx_i,
    input  logic [WIDTH-1:0] xp_i,
    input  logic [WIDTH-1:0] xn_i,
    input  logic [WIDTH-1:0] yp_i,
    input  logic [WIDTH-1:0] yn_i,
    input  logic [WIDTH-1:0] m_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] zp_o,
    output logic [WIDTH-1:0] zn_o,
    output logic [WIDTH-1:0] prev_zp_o,
    output logic [WIDTH-1:0] prev_zn_o
);

    localparam int NITER = WIDTH / DIGITS;
    localparam int CW    = (NITER > 1) ? $clog2(NITER) : 1;
    localparam int AW    = WIDTH + 2;

    if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_params
        $error("mod_arith_seq: DIGITS must be 1, 2 or 4 and divide WIDTH >= 4");
    end

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] m_q, x_q, xn_q, y_q, yn_q, z_q, prev_q;
    logic [AW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             bad_q, done_q, err_q;

    logic             is_mul, bad, last_iter;
    logic [AW-1:0]    m_w, xd, yd, xnorm, ynorm, xa, ya, s, fix;
    logic [DIGITS:0][AW-1:0] chain;
    logic             unused_bits;

    assign is_mul    = (op_q == OP_MUL) || (op_q == OP_SQR);
    assign bad       = (m_q < WIDTH'(2)) || (op_q > 3'd5);
    assign last_iter = (cnt_q == CW'(NITER - 1));

    // Signed-digit to canonical: difference on WIDTH+2 bits, fold negatives by +M
    assign m_w   = {2'b00, m_q};
    assign xd    = {2'b00, x_q} - {2'b00, xn_q};
    assign yd    = {2'b00, y_q} - {2'b00, yn_q};
    assign xnorm = xd[AW-1] ? xd + m_w : xd;
    assign ynorm = yd[AW-1] ? yd + m_w : yd;
    assign unused_bits = ^{xnorm[AW-1:WIDTH], ynorm[AW-1:WIDTH]};

    assign xa = {2'b00, x_q};
    assign ya = {2'b00, y_q};

    always_comb begin
        s = xa + ya;
        case (op_q)
            OP_SUB:  s = xa - ya;
            OP_NEG:  s = '0 - xa;
            OP_DBL:  s = xa + xa;
            default: ;
        endcase
        fix = s[AW-1] ? s + m_w : ((s >= m_w) ? s - m_w : s);
    end

    // Multiplier bits are taken MSB first from the top of x_q, DIGITS per cycle
    assign chain[0] = acc_q;
    for (genvar g = 0; g < DIGITS; g++) begin : g_step
        mod_arith_step #(.WIDTH(WIDTH)) u_step (
            .acc_i (chain[g]),
            .bit_i (x_q[WIDTH-1-g]),
            .y_i   (y_q),
            .m_i   (m_q),
            .acc_o (chain[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en_i) state_d = S_NORM;
            S_NORM:  state_d = bad ? S_FIN : S_EXEC;
            S_EXEC:  if (!is_mul || last_iter) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            m_q     <= '0;
            x_q     <= '0;
            xn_q    <= '0;
            y_q     <= '0;
            yn_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            z_q     <= '0;
            prev_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (clear_i) begin
                z_q    <= '0;
                prev_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: if (en_i) begin
                        op_q <= op_i;
                        m_q  <= m_i;
                        x_q  <= opt_accx_i ? z_q : xp_i;
                        xn_q <= opt_accx_i ? '0 : xn_i;
                        y_q  <= yp_i;
                        yn_q <= yn_i;
                    end
                    S_NORM: begin
                        x_q   <= xnorm[WIDTH-1:0];
                        y_q   <= (op_q == OP_SQR) ? xnorm[WIDTH-1:0] : ynorm[WIDTH-1:0];
                        acc_q <= '0;
                        cnt_q <= '0;
                        bad_q <= bad;
                    end
                    S_EXEC: if (is_mul) begin
                        acc_q <= chain[DIGITS];
                        x_q   <= x_q << DIGITS;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        acc_q <= fix;
                    end
                    S_FIN: begin
                        done_q <= 1'b1;
                        err_q  <= bad_q;
                        if (!bad_q) begin
                            prev_q <= z_q;
                            z_q    <= acc_q[WIDTH-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign zp_o      = z_q;
    assign zn_o      = '0;
    assign prev_zp_o = prev_q;
    assign prev_zn_o = '0;

endmodule
